// File: rtl/time_ascii_sender.sv
// Formats a snapshot of hour/min/sec/centisecond counters as "HH:MM:SS.CC"
// (optionally followed by CR LF) and pushes it byte by byte into a TX FIFO.
module time_ascii_sender #(
   parameter int unsigned ADD_CRLF = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_req,
   input  logic [4:0] hour,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   input  logic [6:0] msec,
   input  logic       fifo_full,
   output logic       o_push,
   output logic [7:0] o_push_data,
   output logic       o_busy,
   output logic       o_done
);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   // Index of the final byte of a frame: '\n' with CRLF, the last centisecond digit without.
   localparam logic [3:0] LastIdx = (ADD_CRLF != 0) ? 4'd12 : 4'd10;

   state_e     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [4:0] hour_q, hour_d;
   logic [5:0] min_q, min_d;
   logic [5:0] sec_q, sec_d;
   logic [6:0] msec_q, msec_d;
   logic       done_q, done_d;
   logic       push;
   logic [7:0] cur_byte;

   // Values above 99 cannot be shown in two digits, so they saturate to 99.
   function automatic logic [6:0] clamp99(input logic [6:0] v);
      return (v > 7'd99) ? 7'd99 : v;
   endfunction

   function automatic logic [7:0] tens_ascii(input logic [6:0] v);
      logic [6:0] c;
      c = clamp99(v);
      return 8'h30 + {1'b0, c / 7'd10};
   endfunction

   function automatic logic [7:0] ones_ascii(input logic [6:0] v);
      logic [6:0] c;
      c = clamp99(v);
      return 8'h30 + {1'b0, c % 7'd10};
   endfunction

   // State, byte index, snapshot and done-pulse registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= 4'd0;
         hour_q  <= 5'd0;
         min_q   <= 6'd0;
         sec_q   <= 6'd0;
         msec_q  <= 7'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hour_q  <= hour_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         msec_q  <= msec_d;
         done_q  <= done_d;
      end
   end

   // Next state: latch the time on a request, step the index on every accepted push.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hour_d  = hour_q;
      min_d   = min_q;
      sec_d   = sec_q;
      msec_d  = msec_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (i_req) begin
               state_d = StSend;
               idx_d   = 4'd0;
               hour_d  = hour;
               min_d   = min;
               sec_d   = sec;
               msec_d  = msec;
            end
         end
         StSend: begin
            if (push) begin
               if (idx_q == LastIdx) begin
                  state_d = StIdle;
                  idx_d   = 4'd0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs: push whenever sending and the FIFO has room; data is the indexed frame byte.
   always_comb begin
      push     = (state_q == StSend) && !fifo_full;
      cur_byte = 8'h00;
      case (idx_q)
         4'd0:    cur_byte = tens_ascii({2'b00, hour_q});
         4'd1:    cur_byte = ones_ascii({2'b00, hour_q});
         4'd2:    cur_byte = 8'h3A;
         4'd3:    cur_byte = tens_ascii({1'b0, min_q});
         4'd4:    cur_byte = ones_ascii({1'b0, min_q});
         4'd5:    cur_byte = 8'h3A;
         4'd6:    cur_byte = tens_ascii({1'b0, sec_q});
         4'd7:    cur_byte = ones_ascii({1'b0, sec_q});
         4'd8:    cur_byte = 8'h2E;
         4'd9:    cur_byte = tens_ascii(msec_q);
         4'd10:   cur_byte = ones_ascii(msec_q);
         4'd11:   cur_byte = 8'h0D;
         4'd12:   cur_byte = 8'h0A;
         default: cur_byte = 8'h00;
      endcase
      o_push      = push;
      o_push_data = (state_q == StSend) ? cur_byte : 8'h00;
      o_busy      = (state_q == StSend);
      o_done      = done_q;
   end

endmodule

// File: tb/tb_time_ascii_sender.sv
// Directed bench for time_ascii_sender: one instance with CRLF, one without.
module tb_time_ascii_sender;

   typedef logic [7:0] byte_q_t [$];

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [4:0] hour;
   logic [5:0] min;
   logic [5:0] sec;
   logic [6:0] msec;
   logic       fifo_full;
   logic       push0, busy0, done0;
   logic [7:0] data0;
   logic       push1, busy1, done1;
   logic [7:0] data1;

   int n_checks   = 0;
   int n_errors   = 0;
   int stall_push = 0;
   int cyc;

   byte_q_t cap0, cap1;
   byte_q_t exp_a, exp_b, exp_c, exp_d, exp_r;

   time_ascii_sender #(.ADD_CRLF(1)) u_dut0 (
      .clk         (clk),
      .rst         (rst),
      .i_req       (req0),
      .hour        (hour),
      .min         (min),
      .sec         (sec),
      .msec        (msec),
      .fifo_full   (fifo_full),
      .o_push      (push0),
      .o_push_data (data0),
      .o_busy      (busy0),
      .o_done      (done0)
   );

   time_ascii_sender #(.ADD_CRLF(0)) u_dut1 (
      .clk         (clk),
      .rst         (rst),
      .i_req       (req1),
      .hour        (hour),
      .min         (min),
      .sec         (sec),
      .msec        (msec),
      .fifo_full   (fifo_full),
      .o_push      (push1),
      .o_push_data (data1),
      .o_busy      (busy1),
      .o_done      (done1)
   );

   always #5 clk = ~clk;

   // Record every byte the FIFO would accept, mid-cycle.
   always @(negedge clk) begin
      if (push0 === 1'b1) begin
         cap0.push_back(data0);
         if (fifo_full) stall_push++;
      end
      if (push1 === 1'b1) begin
         cap1.push_back(data1);
         if (fifo_full) stall_push++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run until the selected instance pulses done; fifo_full is high in SEND cycles lo..hi.
   task automatic run_frame(input bit sel, input int lo, input int hi, input int budget,
                            output int cycles);
      logic d;
      cycles = 0;
      d = sel ? done1 : done0;
      while (!d && cycles < budget) begin
         fifo_full = (cycles >= lo && cycles <= hi);
         tick();
         cycles++;
         d = sel ? done1 : done0;
      end
      fifo_full = 1'b0;
      check("done_seen", {31'd0, d}, 32'd1);
   endtask

   task automatic compare_frame(input string tag, input byte_q_t got, input byte_q_t exp);
      check({tag, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i]});
   endtask

   task automatic set_time(input int h, input int m, input int s, input int c);
      hour = 5'(h);
      min  = 6'(m);
      sec  = 6'(s);
      msec = 7'(c);
   endtask

   task automatic start0();
      req0 = 1'b1;
      tick();
      req0 = 1'b0;
   endtask

   initial begin
      exp_a = '{8'h31, 8'h33, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h34, 8'h32, 8'h2E, 8'h30, 8'h37,
                8'h0D, 8'h0A};
      exp_b = '{8'h30, 8'h39, 8'h3A, 8'h33, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h2E, 8'h35, 8'h35,
                8'h0D, 8'h0A};
      exp_c = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h34, 8'h32, 8'h2E, 8'h39, 8'h39,
                8'h0D, 8'h0A};
      exp_d = '{8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39, 8'h2E, 8'h39, 8'h39};
      exp_r = '{8'h31, 8'h33, 8'h3A, 8'h30};

      rst = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      fifo_full = 1'b0;
      set_time(13, 5, 42, 7);
      tick();
      tick();
      check("rst_push", {31'd0, push0}, 32'd0);
      check("rst_data", {24'd0, data0}, 32'd0);
      check("rst_busy", {31'd0, busy0}, 32'd0);
      check("rst_done", {31'd0, done0}, 32'd0);
      rst = 1'b0;
      tick();
      check("idle_data", {24'd0, data0}, 32'd0);

      // Basic frame: first byte available the cycle after the request edge.
      start0();
      check("first_busy", {31'd0, busy0}, 32'd1);
      check("first_push", {31'd0, push0}, 32'd1);
      check("first_data", {24'd0, data0}, 32'h31);
      run_frame(1'b0, -1, -2, 40, cyc);
      check("basic_cycles", cyc, 13);
      check("done_busy", {31'd0, busy0}, 32'd0);
      check("done_push", {31'd0, push0}, 32'd0);
      compare_frame("basic", cap0, exp_a);
      cap0.delete();
      tick();
      check("done_one_cycle", {31'd0, done0}, 32'd0);

      // FIFO full during the 3rd-5th SEND cycles stretches the frame to 16 cycles.
      start0();
      run_frame(1'b0, 2, 4, 40, cyc);
      check("stall_cycles", cyc, 16);
      compare_frame("stall", cap0, exp_a);
      cap0.delete();
      tick();

      // Inputs cleared right after the request must not disturb the snapshot.
      start0();
      set_time(0, 0, 0, 0);
      run_frame(1'b0, -1, -2, 40, cyc);
      compare_frame("snap", cap0, exp_a);
      cap0.delete();
      tick();

      // Mid-frame request ignored; request on the done cycle starts a fresh frame.
      set_time(13, 5, 42, 7);
      start0();
      tick();
      tick();
      tick();
      start0();
      run_frame(1'b0, -1, -2, 40, cyc);
      check("ignore_cycles", cyc, 9);
      compare_frame("ignore", cap0, exp_a);
      cap0.delete();
      check("back2back_idle", {31'd0, busy0}, 32'd0);
      set_time(9, 30, 0, 55);
      start0();
      check("back2back_done", {31'd0, done0}, 32'd0);
      check("back2back_busy", {31'd0, busy0}, 32'd1);
      run_frame(1'b0, -1, -2, 40, cyc);
      compare_frame("second", cap0, exp_b);
      cap0.delete();
      tick();

      // Reset during the push of the 4th byte abandons the frame.
      set_time(13, 5, 42, 7);
      start0();
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_push", {31'd0, push0}, 32'd0);
      check("mid_rst_busy", {31'd0, busy0}, 32'd0);
      check("mid_rst_data", {24'd0, data0}, 32'd0);
      check("mid_rst_done", {31'd0, done0}, 32'd0);
      tick();
      tick();
      compare_frame("abandon", cap0, exp_r);
      cap0.delete();

      // Reset wins over a simultaneous request.
      rst = 1'b1;
      req0 = 1'b1;
      tick();
      rst = 1'b0;
      req0 = 1'b0;
      check("rst_prio_busy", {31'd0, busy0}, 32'd0);
      tick();
      check("rst_prio_push", cap0.size(), 0);

      // Restart after reset with an out-of-range centisecond value.
      set_time(0, 5, 42, 120);
      start0();
      run_frame(1'b0, -1, -2, 40, cyc);
      compare_frame("clamp", cap0, exp_c);
      cap0.delete();
      tick();

      // No line terminator variant.
      set_time(23, 59, 59, 99);
      req1 = 1'b1;
      tick();
      req1 = 1'b0;
      run_frame(1'b1, -1, -2, 40, cyc);
      check("nocrlf_cycles", cyc, 11);
      compare_frame("nocrlf", cap1, exp_d);
      check("nocrlf_other_idle", cap0.size(), 0);
      tick();

      check("no_push_when_full", stall_push, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/time_ascii_sender.md
TIME_ASCII_SENDER -- requirements
Module: time_ascii_sender

Interface
REQ-001 Parameter: ADD_CRLF, default 1, meaning 1 = append CR LF to each frame, 0 = no line terminator.
REQ-002 clk  input  1  system clock; all logic is rising-edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 i_req  input  1  one-cycle request to report the current time.
REQ-005 hour  input  5  hours, binary, 0-23.
REQ-006 min  input  6  minutes, binary, 0-59.
REQ-007 sec  input  6  seconds, binary, 0-59.
REQ-008 msec  input  7  centiseconds, binary, 0-99.
REQ-009 fifo_full  input  1  downstream TX FIFO full; no push allowed while high.
REQ-010 o_push  output  1  FIFO write strobe, one byte per high cycle.
REQ-011 o_push_data  output  8  ASCII byte, valid when o_push=1.
REQ-012 o_busy  output  1  high while a frame is in progress.
REQ-013 o_done  output  1  one-cycle pulse after the last byte of a frame is pushed.

Function
REQ-014 The FSM SHALL have states IDLE and SEND; o_busy = (state==SEND).
REQ-015 In IDLE, i_req=1 SHALL latch hour/min/sec/msec into snapshot registers at that edge, clear the byte index to 0, and enter SEND.
REQ-016 The frame SHALL be H1 H0 ':' M1 M0 ':' S1 S0 '.' C1 C0, then 0x0D 0x0A if ADD_CRLF=1: 13 bytes with CRLF, 11 without.
REQ-017 Each field SHALL convert as tens = value/10 and ones = value%10, each emitted as 8'h30 + digit.
REQ-018 Any snapshot value greater than 99 (msec 100-127) SHALL emit "99"; other fields are emitted unclamped.
REQ-019 o_push SHALL be combinational: (state==SEND) && !fifo_full.
REQ-020 o_push_data SHALL be the byte selected by the current index from the snapshot; it is 8'h00 in IDLE.
REQ-021 The index SHALL advance only on a cycle with o_push=1.
REQ-022 While fifo_full=1, the index and data SHALL hold and no byte is lost or duplicated.
REQ-023 On the push of the last byte, the FSM SHALL return to IDLE, and o_done SHALL pulse in the following cycle.
REQ-024 Latency: i_req at edge N SHALL make the first o_push possible in cycle N+1; with fifo_full=0 the bytes are pushed on consecutive cycles.
REQ-025 i_req while in SEND SHALL be ignored (not queued); input changes during SEND SHALL NOT affect the frame.
REQ-026 i_req in the same cycle as o_done (FSM already in IDLE) SHALL start a new frame normally.

Reset
REQ-027 rst=1 SHALL force state to IDLE, index to 0, snapshot registers to 0, o_done to 0, o_push to 0 and o_push_data to 8'h00 from the next edge.
REQ-028 Reset mid-frame SHALL abandon the frame with no further pushes; the next i_req SHALL start from byte 0.
REQ-029 rst SHALL take priority over i_req in the same cycle.

Verification
REQ-030 hour=13, min=5, sec=42, msec=7, i_req, fifo_full=0 -> 31 33 3A 30 35 3A 34 32 2E 30 37 0D 0A on 13 consecutive cycles, then o_done for 1 cycle.
REQ-031 Same stimulus with fifo_full=1 during the 3rd-5th cycles of SEND -> identical byte sequence, no push while full, frame takes 16 cycles.
REQ-032 All inputs changed to 0 one cycle after i_req -> frame still reads "13:05:42.07".
REQ-033 Second i_req mid-frame -> ignored, exactly one frame; i_req after o_done -> second full frame.
REQ-034 rst after the 4th byte -> o_push=0 and o_busy=0 next cycle; a new i_req with hour=0, msec=120 -> frame starts "00:" and ends ".99".
REQ-035 ADD_CRLF=0, hour=23, min=59, sec=59, msec=99 -> 11 bytes "23:59:59.99", no 0D/0A.
